// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory bus between an instruction fetch port and a
// load/store port, with byte-lane steering, alignment checking and a bus-wait timeout.
module mem_arbiter #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_align_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);

  localparam logic [2:0] OP_LB = 3'd1;
  localparam logic [2:0] OP_LW = 3'd2;
  localparam logic [2:0] OP_SB = 3'd3;
  localparam logic [2:0] OP_SW = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_XFER  = 2'd1,
    MEM_XFER = 2'd2
  } state_t;

  state_t          state_r;
  logic            last_mem_r;
  logic [CW-1:0]   wait_cnt_r;
  logic [2:0]      op_r;
  logic [1:0]      off_r;

  logic            if_elig_s;
  logic            mem_elig_s;
  logic            grant_if_s;
  logic            grant_mem_s;
  logic            misalign_s;
  logic            limit_hit_s;
  logic [CW-1:0]   wait_nxt_s;
  logic            mem_we_s;
  logic [3:0]      mem_be_s;
  logic [31:0]     mem_wdata_s;
  logic            if_addr_unused_s;

  function automatic logic op_valid(input logic [2:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

  // Little-endian byte select with sign extension for LB; stores return zero.
  function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    case (op)
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LW:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  assign if_addr_unused_s = ^if_addr[1:0];
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = op_valid(mem_op) & ~mem_done;

  // Grant selection: MEM wins unless it won last time and IF is waiting.
  always_comb begin
    if_elig_s   = if_req & ~if_done;
    mem_elig_s  = op_valid(mem_op) & ~mem_done;
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    if (state_r == IDLE) begin
      if (if_elig_s && (last_mem_r || !mem_elig_s)) begin
        grant_if_s = 1'b1;
      end else if (mem_elig_s) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
      end
    end else begin
      grant_if_s  = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  // Data-port request decode: write enable, byte lanes and replicated store data.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_be_s    = 4'hF;
    mem_wdata_s = 32'h0000_0000;
    misalign_s  = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00);
    case (mem_op)
      OP_LB: begin
        mem_be_s = lane_be(mem_addr[1:0]);
      end
      OP_LW: begin
        mem_be_s = 4'hF;
      end
      OP_SB: begin
        mem_we_s    = 1'b1;
        mem_be_s    = lane_be(mem_addr[1:0]);
        mem_wdata_s = {4{mem_wdata[7:0]}};
      end
      OP_SW: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = mem_wdata;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // The limit counts XFER cycles without ack; ack in the limit cycle still wins.
  always_comb begin
    wait_nxt_s  = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    limit_hit_s = (wait_nxt_s >= LIMIT_C);
  end

  // Arbiter FSM with all bus and completion outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= IDLE;
      last_mem_r    <= 1'b0;
      wait_cnt_r    <= '0;
      op_r          <= 3'd0;
      off_r         <= 2'd0;
      if_rdata      <= 32'h0000_0000;
      if_done       <= 1'b0;
      mem_rdata     <= 32'h0000_0000;
      mem_done      <= 1'b0;
      mem_align_err <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= 32'h0000_0000;
      bus_wdata     <= 32'h0000_0000;
      bus_be        <= 4'h0;
      bus_err       <= 1'b0;
    end else begin
      if_done       <= 1'b0;
      mem_done      <= 1'b0;
      mem_align_err <= 1'b0;
      bus_err       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_mem_s) begin
            last_mem_r <= 1'b1;
            wait_cnt_r <= '0;
            if (misalign_s) begin
              mem_done      <= 1'b1;
              mem_align_err <= 1'b1;
              mem_rdata     <= 32'h0000_0000;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_we_s;
              bus_addr  <= {mem_addr[31:2], 2'b00};
              bus_wdata <= mem_wdata_s;
              bus_be    <= mem_be_s;
              op_r      <= mem_op;
              off_r     <= mem_addr[1:0];
              state_r   <= MEM_XFER;
            end
          end else if (grant_if_s) begin
            last_mem_r <= 1'b0;
            wait_cnt_r <= '0;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= {if_addr[31:2], 2'b00};
            bus_wdata  <= 32'h0000_0000;
            bus_be     <= 4'hF;
            state_r    <= IF_XFER;
          end else begin
            state_r <= IDLE;
          end
        end
        IF_XFER: begin
          if (bus_ack || limit_hit_s) begin
            if_done   <= 1'b1;
            if_rdata  <= bus_ack ? bus_rdata : 32'h0000_0000;
            bus_err   <= ~bus_ack;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_wdata <= 32'h0000_0000;
            bus_be    <= 4'h0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_nxt_s;
          end
        end
        MEM_XFER: begin
          if (bus_ack || limit_hit_s) begin
            mem_done  <= 1'b1;
            mem_rdata <= bus_ack ? load_data(op_r, off_r, bus_rdata) : 32'h0000_0000;
            bus_err   <= ~bus_ack;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_wdata <= 32'h0000_0000;
            bus_be    <= 4'h0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_nxt_s;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 16, giving the maximum cycles a granted transfer waits for bus_ack before abort.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the port if_req, input, 1 bit: fetch request, held until if_done.
REQ-005 The block SHALL have the port if_addr, input, 32 bits: fetch address, word aligned.
REQ-006 The block SHALL have the ports if_rdata, output, 32 bits, and if_done, output, 1 bit: fetched word and one-cycle completion pulse.
REQ-007 The block SHALL have the port mem_op, input, 3 bits: 0 none, 1 LB, 2 LW, 3 SB, 4 SW; 5-7 treated as 0.
REQ-008 The block SHALL have the ports mem_addr and mem_wdata, input, 32 bits each: data address and store data (SB uses bits 7:0).
REQ-009 The block SHALL have the ports mem_rdata, output, 32 bits; mem_done, output, 1 bit; and mem_align_err, output, 1 bit: load result, completion pulse, misalignment pulse.
REQ-010 The block SHALL have the ports bus_req, output, 1; bus_we, output, 1; bus_addr, output, 32; bus_wdata, output, 32; bus_be, output, 4: the shared single-port memory request.
REQ-011 The block SHALL have the ports bus_ack, input, 1, and bus_rdata, input, 32: transfer accept and read data valid in the ack cycle.
REQ-012 The block SHALL have the ports bus_err, output, 1 (timeout pulse), and stall_if and stall_mem, outputs, 1 bit each: pipeline hold requests.

Function
REQ-013 The FSM SHALL have states IDLE, IF_XFER and MEM_XFER.
REQ-014 In IDLE, an eligible MEM request SHALL be granted before an eligible IF request, except when the previous grant was MEM and IF is eligible; then IF is granted.
REQ-015 A requester whose done pulse is high in the current cycle SHALL be ineligible for grant that cycle.
REQ-016 A grant SHALL register bus_req=1 and the stable address, bus_we, bus_wdata and bus_be, entering the XFER state on the next edge.
REQ-017 In XFER, a cycle with bus_ack=1 SHALL complete the transfer and capture the data; bus_req=0 and the matching done=1 SHALL follow on the next cycle, with state IDLE.
REQ-018 Fetch SHALL use bus_be=4'hF, bus_we=0 and bus_addr={if_addr[31:2],2'b00}, and SHALL set if_rdata=bus_rdata.
REQ-019 LW SHALL use bus_be=4'hF and bus_we=0, and SHALL set mem_rdata=bus_rdata.
REQ-020 LB SHALL use bus_be=4'b0001<<mem_addr[1:0] and bus_we=0, and SHALL set mem_rdata to the sign-extended byte selected by mem_addr[1:0] (little-endian).
REQ-021 SW SHALL use bus_we=1, bus_be=4'hF and bus_wdata=mem_wdata; SB SHALL use bus_we=1, bus_be=4'b0001<<mem_addr[1:0] and bus_wdata={4{mem_wdata[7:0]}}.
REQ-022 For all data ops, bus_addr SHALL be {mem_addr[31:2],2'b00}.
REQ-023 LW or SW with mem_addr[1:0]!=0 SHALL issue no bus transfer; mem_done and mem_align_err SHALL pulse one cycle after grant, with mem_rdata=0.
REQ-024 A wait counter SHALL clear on grant and increment per XFER cycle without ack.
REQ-025 When the wait counter reaches WAIT_LIMIT without ack, the transfer SHALL abort: next cycle bus_req=0, done=1, rdata=0, bus_err=1 for one cycle, state IDLE.
REQ-026 If bus_ack arrives in the same cycle the limit is reached, the transfer SHALL complete normally with no bus_err.
REQ-027 stall_if SHALL equal if_req & ~if_done, and stall_mem SHALL equal (mem_op in 1..4) & ~mem_done, both combinational.
REQ-028 bus_ack outside an XFER state SHALL be ignored.
REQ-029 Done, bus_err and mem_align_err SHALL be single-cycle pulses, and if_done and mem_done SHALL never be high in the same cycle.

Reset
REQ-030 When rstn=0 at a clock edge, the block SHALL go to state IDLE, with all outputs 0, the wait counter 0, and last-grant=IF.
REQ-031 Reset during an XFER state SHALL abort the transfer with no done pulse; bus_req SHALL be 0 from the first cycle after the reset edge.

Verification
REQ-032 The bench SHALL cover: if_req=1, if_addr=0x100, bus_ack after 2 wait cycles with bus_rdata=0xDEADBEEF -> if_done one pulse, if_rdata=0xDEADBEEF, stall_if high until the done cycle.
REQ-033 The bench SHALL cover: IF and LW requested simultaneously from IDLE -> MEM granted first, then IF; with a new LW held high, IF is still served before the second LW.
REQ-034 The bench SHALL cover: LB at mem_addr=0x203 with bus_rdata=0x80112233 -> bus_be=4'b1000, mem_rdata=0xFFFFFF80.
REQ-035 The bench SHALL cover: SB at mem_addr=0x301, mem_wdata=0x000000A5 -> bus_we=1, bus_be=4'b0010, bus_wdata=0xA5A5A5A5.
REQ-036 The bench SHALL cover: SW at mem_addr=0x402 -> no bus_req, and mem_done with mem_align_err one cycle after grant.
REQ-037 The bench SHALL cover: bus_ack held 0 -> abort after 16 wait cycles with bus_err pulse and rdata=0; then rstn=0 mid-XFER -> bus_req=0 next cycle and no done.
